dmi_target: RTL and testbench

Synthesizable DMI responder: the target end of the debug-module-interface request/response channel driven by the simulation DTM. It accepts DMI read/write/nop requests, services a reduced RISC-V debug-module register set (data, dmcontrol, dmstatus, abstractcs, command, progbuf) and returns one response per request. Response latency is programmable. It serves as a bench stand-in for the real debug module and as a DTM regression target.

---
 rtl/dmi_pkg.sv | 29 ++
 rtl/dmi_target_regs.sv | 96 +++++++++
 rtl/dmi_target.sv | 62 ++++++
 tb/tb_dmi_target.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmi_pkg.sv
// dmi_pkg: shared DMI op/resp codes, register map and debug-module field positions
package dmi_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2, OP_RSVD = 2'd3} dmi_op_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} dmi_state_e;
  localparam logic [1:0] RESP_OK = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [6:0] A_DATA0 = 7'h04;
  localparam logic [6:0] A_DATA1 = 7'h05;
  localparam logic [6:0] A_DMCONTROL = 7'h10;
  localparam logic [6:0] A_DMSTATUS = 7'h11;
  localparam logic [6:0] A_ABSTRACTCS = 7'h16;
  localparam logic [6:0] A_COMMAND = 7'h17;
  localparam logic [6:0] A_PROGBUF0 = 7'h20;
  localparam logic [6:0] A_PROGBUF1 = 7'h21;
  localparam int DMC_HALTREQ = 31;
  localparam int DMC_RESUMEREQ = 30;
  localparam int DMC_NDMRESET = 1;
  localparam int DMC_DMACTIVE = 0;
  localparam int DMS_ALLRESUMEACK = 17;
  localparam int DMS_ALLRUNNING = 11;
  localparam int DMS_ALLHALTED = 9;
  localparam int DMS_AUTHENTICATED = 7;
  localparam logic [3:0] DMS_VERSION = 4'd2;
  localparam int ACS_BUSY = 12;
  localparam logic [4:0] ACS_PROGBUFSIZE = 5'd2;
  localparam logic [3:0] ACS_DATACOUNT = 4'd2;
  localparam logic [2:0] CMDERR_BUSY = 3'd1;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
endpackage

// File: rtl/dmi_target_regs.sv
// dmi_target_regs: debug-module register file, halt/resume and abstract-command busy tracking
module dmi_target_regs
  import dmi_pkg::*;
#(
  parameter int CMD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        halted,
  output logic        ndmreset
);
  logic [31:0] data0, data1, progbuf0, progbuf1, mux;
  logic        dmactive, resumeack, busy, guarded, go, blocked;
  logic [2:0]  cmderr;
  logic [7:0]  busy_cnt;
  assign busy = |busy_cnt;
  assign guarded = addr == A_DATA0 || addr == A_DATA1 || addr == A_PROGBUF0 || addr == A_PROGBUF1 ||
                   addr == A_ABSTRACTCS || addr == A_COMMAND;
  assign go = wr_en && dmactive && !busy;
  assign blocked = wr_en && dmactive && busy && guarded;
  always_ff @(posedge clk) begin
    if (reset) begin
      {data0, data1, progbuf0, progbuf1} <= '0;
      {dmactive, ndmreset, halted, resumeack} <= '0;
      cmderr <= '0;
      busy_cnt <= '0;
    end else begin
      if (busy) busy_cnt <= busy_cnt - 8'd1;
      if (blocked && cmderr == 3'd0) cmderr <= CMDERR_BUSY;
      if (go)
        case (addr)
          A_DATA0: data0 <= wdata;
          A_DATA1: data1 <= wdata;
          A_PROGBUF0: progbuf0 <= wdata;
          A_PROGBUF1: progbuf1 <= wdata;
          A_ABSTRACTCS: cmderr <= cmderr & ~wdata[10:8];
          A_COMMAND:
            if (cmderr == 3'd0) begin
              if (halted) busy_cnt <= 8'(CMD_CYCLES);
              else cmderr <= CMDERR_HALTRESUME;
            end
          default: ;
        endcase
      // dmcontrol is always writable; the written dmactive bit gates halt/resume
      if (wr_en && addr == A_DMCONTROL) begin
        dmactive <= wdata[DMC_DMACTIVE];
        ndmreset <= wdata[DMC_NDMRESET];
        if (!wdata[DMC_DMACTIVE]) begin
          {data0, data1, progbuf0, progbuf1} <= '0;
          cmderr <= '0;
          halted <= 1'b0;
          resumeack <= 1'b0;
        end else if (wdata[DMC_HALTREQ]) begin
          halted <= 1'b1;
          resumeack <= 1'b0;
        end else if (wdata[DMC_RESUMEREQ] && halted) begin
          halted <= 1'b0;
          resumeack <= 1'b1;
        end
      end
    end
  end
  always_comb begin
    mux = '0;
    case (addr)
      A_DATA0: mux = data0;
      A_DATA1: mux = data1;
      A_PROGBUF0: mux = progbuf0;
      A_PROGBUF1: mux = progbuf1;
      A_DMCONTROL: begin
        mux[DMC_NDMRESET] = ndmreset;
        mux[DMC_DMACTIVE] = dmactive;
      end
      A_DMSTATUS: begin
        mux[DMS_ALLRESUMEACK] = resumeack;
        mux[DMS_ALLRUNNING] = !halted;
        mux[DMS_ALLHALTED] = halted;
        mux[DMS_AUTHENTICATED] = 1'b1;
        mux[3:0] = DMS_VERSION;
      end
      A_ABSTRACTCS: begin
        mux[28:24] = ACS_PROGBUFSIZE;
        mux[ACS_BUSY] = busy;
        mux[10:8] = cmderr;
        mux[3:0] = ACS_DATACOUNT;
      end
      default: ;
    endcase
    rdata = rd_en ? mux : '0;
  end
endmodule

// File: rtl/dmi_target.sv
// dmi_target: DMI responder with programmable response latency in front of dmi_target_regs
module dmi_target
  import dmi_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int CMD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        debug_req_valid,
  output logic        debug_req_ready,
  input  logic [6:0]  debug_req_bits_addr,
  input  logic [1:0]  debug_req_bits_op,
  input  logic [31:0] debug_req_bits_data,
  output logic        debug_resp_valid,
  input  logic        debug_resp_ready,
  output logic [1:0]  debug_resp_bits_resp,
  output logic [31:0] debug_resp_bits_data,
  output logic        halted,
  output logic        ndmreset
);
  localparam logic [3:0] LAT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
  dmi_state_e  state, state_d;
  logic [3:0]  lat_cnt;
  logic [31:0] rdata;
  logic        accept;
  assign debug_req_ready = state == S_IDLE;
  assign debug_resp_valid = state == S_RESP;
  assign accept = debug_req_valid && debug_req_ready;
  dmi_target_regs #(.CMD_CYCLES(CMD_CYCLES)) u_regs (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept && debug_req_bits_op == OP_WRITE),
    .rd_en   (accept && debug_req_bits_op == OP_READ),
    .addr    (debug_req_bits_addr),
    .wdata   (debug_req_bits_data),
    .rdata   (rdata),
    .halted  (halted),
    .ndmreset(ndmreset)
  );
  always_comb
    state_d = state == S_IDLE ? (accept ? (LATENCY == 1 ? S_RESP : S_WAIT) : S_IDLE) :
              state == S_WAIT ? (lat_cnt == 4'd0 ? S_RESP : S_WAIT) :
              (debug_resp_ready ? S_IDLE : S_RESP);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      lat_cnt <= '0;
      debug_resp_bits_resp <= RESP_OK;
      debug_resp_bits_data <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        lat_cnt <= LAT_INIT;
        debug_resp_bits_resp <= debug_req_bits_op == OP_RSVD ? RESP_FAIL : RESP_OK;
        debug_resp_bits_data <= rdata;
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_dmi_target.sv
// tb_dmi_target: table-driven DMI vectors plus hand-timed busy, stall and reset sequences
module tb_dmi_target;
  localparam int LATENCY = 2;
  localparam int CMD_CYCLES = 8;
  logic        clk = 1'b0;
  logic        reset;
  logic        debug_req_valid, debug_req_ready, debug_resp_valid, debug_resp_ready;
  logic [6:0]  debug_req_bits_addr;
  logic [1:0]  debug_req_bits_op, debug_resp_bits_resp;
  logic [31:0] debug_req_bits_data, debug_resp_bits_data;
  logic        halted, ndmreset;
  int          n_vec = 0;
  int          n_err = 0;
  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wd;
    logic [1:0]  resp;
    logic [31:0] data;
    logic        halt;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  dmi_target #(.LATENCY(LATENCY), .CMD_CYCLES(CMD_CYCLES)) dut (
    .clk                 (clk),
    .reset               (reset),
    .debug_req_valid     (debug_req_valid),
    .debug_req_ready     (debug_req_ready),
    .debug_req_bits_addr (debug_req_bits_addr),
    .debug_req_bits_op   (debug_req_bits_op),
    .debug_req_bits_data (debug_req_bits_data),
    .debug_resp_valid    (debug_resp_valid),
    .debug_resp_ready    (debug_resp_ready),
    .debug_resp_bits_resp(debug_resp_bits_resp),
    .debug_resp_bits_data(debug_resp_bits_data),
    .halted              (halted),
    .ndmreset            (ndmreset)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                     input logic [1:0] resp, input logic [31:0] data, input logic halt);
    vec_t v;
    v.op = op; v.addr = addr; v.wd = wd; v.resp = resp; v.data = data; v.halt = halt;
    tv.push_back(v);
  endtask
  task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd, input string nm);
    int k = 0;
    while (!debug_req_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk({nm, " req_ready"}, debug_req_ready, 1);
    debug_req_valid = 1'b1;
    debug_req_bits_op = op;
    debug_req_bits_addr = addr;
    debug_req_bits_data = wd;
    @(posedge clk); #1;
    debug_req_valid = 1'b0;
    debug_req_bits_data = 32'hx;
  endtask
  task automatic xfer(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                      input logic [1:0] er, input logic [31:0] ed, input string nm);
    int k = 1;
    issue(op, addr, wd, nm);
    chk({nm, " busy_ready"}, debug_req_ready, 0);
    while (!debug_resp_valid && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk({nm, " latency"}, k, LATENCY);
    chk({nm, " resp"}, debug_resp_bits_resp, er);
    chk({nm, " data"}, debug_resp_bits_data, ed);
    debug_resp_ready = 1'b1;
    @(posedge clk); #1;
    debug_resp_ready = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    debug_req_valid = 1'b0;
    debug_req_bits_op = 2'd0;
    debug_req_bits_addr = 7'd0;
    debug_req_bits_data = 32'd0;
    debug_resp_ready = 1'b0;
    add(2'd1, 7'h11, 0, 2'd0, 32'h00000882, 0);
    add(2'd2, 7'h10, 32'h00000001, 2'd0, 0, 0);
    add(2'd2, 7'h04, 32'hDEADBEEF, 2'd0, 0, 0);
    add(2'd1, 7'h04, 0, 2'd0, 32'hDEADBEEF, 0);
    add(2'd2, 7'h05, 32'h12345678, 2'd0, 0, 0);
    add(2'd1, 7'h05, 0, 2'd0, 32'h12345678, 0);
    add(2'd2, 7'h20, 32'hA5A5A5A5, 2'd0, 0, 0);
    add(2'd1, 7'h20, 0, 2'd0, 32'hA5A5A5A5, 0);
    add(2'd1, 7'h21, 0, 2'd0, 0, 0);
    add(2'd2, 7'h21, 32'h0F0F0F0F, 2'd0, 0, 0);
    add(2'd1, 7'h21, 0, 2'd0, 32'h0F0F0F0F, 0);
    add(2'd1, 7'h10, 0, 2'd0, 32'h00000001, 0);
    add(2'd1, 7'h16, 0, 2'd0, 32'h02000002, 0);
    add(2'd1, 7'h17, 0, 2'd0, 0, 0);
    add(2'd1, 7'h7F, 0, 2'd0, 0, 0);
    add(2'd2, 7'h11, 32'hFFFFFFFF, 2'd0, 0, 0);
    add(2'd1, 7'h11, 0, 2'd0, 32'h00000882, 0);
    add(2'd0, 7'h04, 32'h00001234, 2'd0, 0, 0);
    add(2'd1, 7'h04, 0, 2'd0, 32'hDEADBEEF, 0);
    add(2'd2, 7'h17, 0, 2'd0, 0, 0);
    add(2'd1, 7'h16, 0, 2'd0, 32'h02000402, 0);
    add(2'd2, 7'h17, 0, 2'd0, 0, 0);
    add(2'd1, 7'h16, 0, 2'd0, 32'h02000402, 0);
    add(2'd2, 7'h16, 32'h00000400, 2'd0, 0, 0);
    add(2'd1, 7'h16, 0, 2'd0, 32'h02000002, 0);
    add(2'd2, 7'h10, 32'h00000000, 2'd0, 0, 0);
    add(2'd1, 7'h04, 0, 2'd0, 0, 0);
    add(2'd1, 7'h21, 0, 2'd0, 0, 0);
    add(2'd2, 7'h04, 32'h11111111, 2'd0, 0, 0);
    add(2'd1, 7'h04, 0, 2'd0, 0, 0);
    add(2'd1, 7'h10, 0, 2'd0, 0, 0);
    add(2'd2, 7'h10, 32'h80000001, 2'd0, 0, 1);
    add(2'd1, 7'h11, 0, 2'd0, 32'h00000282, 1);
    add(2'd2, 7'h10, 32'h40000001, 2'd0, 0, 0);
    add(2'd1, 7'h11, 0, 2'd0, 32'h00020882, 0);
    add(2'd2, 7'h10, 32'hC0000001, 2'd0, 0, 1);
    add(2'd1, 7'h11, 0, 2'd0, 32'h00000282, 1);
    add(2'd2, 7'h10, 32'hC0000001, 2'd0, 0, 1);
    add(2'd1, 7'h11, 0, 2'd0, 32'h00000282, 1);
    add(2'd1, 7'h10, 0, 2'd0, 32'h00000001, 1);
    add(2'd2, 7'h04, 32'hCAFEF00D, 2'd0, 0, 1);
    add(2'd2, 7'h05, 32'h12345678, 2'd0, 0, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst req_ready", debug_req_ready, 1);
    chk("rst resp_valid", debug_resp_valid, 0);
    chk("rst resp", debug_resp_bits_resp, 0);
    chk("rst data", debug_resp_bits_data, 0);
    chk("rst halted", halted, 0);
    chk("rst ndmreset", ndmreset, 0);
    foreach (tv[i]) begin
      xfer(tv[i].op, tv[i].addr, tv[i].wd, tv[i].resp, tv[i].data, $sformatf("v%0d", i));
      chk($sformatf("v%0d halted", i), halted, tv[i].halt);
    end
    // command then an immediate data0 write lands inside the busy window
    xfer(2'd2, 7'h17, 0, 2'd0, 0, "cmd");
    xfer(2'd2, 7'h04, 32'h11111111, 2'd0, 0, "busy wr data0");
    xfer(2'd1, 7'h16, 0, 2'd0, 32'h02001102, "acs busy");
    xfer(2'd1, 7'h04, 0, 2'd0, 32'hCAFEF00D, "data0 kept");
    xfer(2'd1, 7'h16, 0, 2'd0, 32'h02000102, "acs done");
    xfer(2'd2, 7'h16, 32'h00000700, 2'd0, 0, "w1c");
    xfer(2'd1, 7'h16, 0, 2'd0, 32'h02000002, "acs clear");
    xfer(2'd2, 7'h17, 0, 2'd0, 0, "cmd2");
    repeat (5) @(posedge clk);
    #1;
    xfer(2'd2, 7'h05, 32'hBAD0BAD0, 2'd0, 0, "last busy wr");
    xfer(2'd1, 7'h16, 0, 2'd0, 32'h02000102, "acs last busy");
    xfer(2'd1, 7'h05, 0, 2'd0, 32'h12345678, "data1 kept");
    xfer(2'd2, 7'h17, 0, 2'd0, 0, "cmd err set");
    xfer(2'd1, 7'h16, 0, 2'd0, 32'h02000102, "cmd ignored");
    xfer(2'd2, 7'h16, 32'h00000700, 2'd0, 0, "w1c2");
    xfer(2'd2, 7'h17, 0, 2'd0, 0, "cmd3");
    repeat (6) @(posedge clk);
    #1;
    xfer(2'd2, 7'h05, 32'h600D600D, 2'd0, 0, "after busy wr");
    xfer(2'd1, 7'h16, 0, 2'd0, 32'h02000002, "acs idle");
    xfer(2'd1, 7'h05, 0, 2'd0, 32'h600D600D, "data1 new");
    issue(2'd3, 7'h04, 32'h55555555, "op3");
    repeat (LATENCY - 1) @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall%0d valid", c), debug_resp_valid, 1);
      chk($sformatf("stall%0d resp", c), debug_resp_bits_resp, 2);
      chk($sformatf("stall%0d data", c), debug_resp_bits_data, 0);
      chk($sformatf("stall%0d ready", c), debug_req_ready, 0);
      @(posedge clk); #1;
    end
    debug_resp_ready = 1'b1;
    @(posedge clk); #1;
    debug_resp_ready = 1'b0;
    chk("post stall ready", debug_req_ready, 1);
    xfer(2'd1, 7'h04, 0, 2'd0, 32'hCAFEF00D, "op3 no effect");
    xfer(2'd2, 7'h10, 32'h80000003, 2'd0, 0, "ndm set");
    chk("ndmreset set", ndmreset, 1);
    issue(2'd1, 7'h04, 0, "pre reset rd");
    chk("in wait", debug_resp_valid, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid rst req_ready", debug_req_ready, 1);
    chk("mid rst halted", halted, 0);
    chk("mid rst ndmreset", ndmreset, 0);
    chk("mid rst resp", debug_resp_bits_resp, 0);
    chk("mid rst data", debug_resp_bits_data, 0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("dropped%0d", c), debug_resp_valid, 0);
      @(posedge clk); #1;
    end
    xfer(2'd1, 7'h04, 0, 2'd0, 0, "rst data0");
    xfer(2'd1, 7'h05, 0, 2'd0, 0, "rst data1");
    xfer(2'd1, 7'h20, 0, 2'd0, 0, "rst progbuf0");
    xfer(2'd1, 7'h21, 0, 2'd0, 0, "rst progbuf1");
    xfer(2'd1, 7'h10, 0, 2'd0, 0, "rst dmcontrol");
    xfer(2'd1, 7'h16, 0, 2'd0, 32'h02000002, "rst abstractcs");
    xfer(2'd1, 7'h11, 0, 2'd0, 32'h00000882, "rst dmstatus");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
